fft_mm_master: RTL and testbench
================================

FFT_MM_MASTER -- requirements
Module: fft_mm_master

Interface
REQ-001 Parameter POLL_GAP, default 4: idle cycles between successive status polls.
REQ-002 Parameter TIMEOUT, default 1024: maximum status reads before abort.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 cmd_start  in  1  one-cycle request to run one FFT job; sampled only in IDLE.
REQ-006 sample_in  in  128  four 32-bit sample words, word k = bits [32k+31:32k]; captured on accepted cmd_start.
REQ-007 busy  out  1  high in every state except IDLE.
REQ-008 result_out  out  128  real result words, word k read from slave address k+1.
REQ-009 result_valid  out  1  one-cycle pulse when result_out is updated.
REQ-010 timeout_err  out  1  one-cycle pulse when a job is aborted on timeout.
REQ-011 avm_address  out  32  Avalon-MM word address to the FFT slave.
REQ-012 avm_write  out  1  Avalon-MM write strobe.
REQ-013 avm_read  out  1  Avalon-MM read strobe.
REQ-014 avm_writedata  out  32  Avalon-MM write data.
REQ-015 avm_readdata  in  32  Avalon-MM read data, valid in the cycle avm_read is high and avm_waitrequest is low (zero read latency).
REQ-016 avm_waitrequest  in  1  slave stall.

Function
REQ-017 The block SHALL implement states IDLE, WR_DATA, WR_START, POLL_RD, POLL_WAIT, RD_RES, DONE, ERR.
REQ-018 The block SHALL accept cmd_start in IDLE only: latch sample_in, clear the word index and poll count, enter WR_DATA next cycle; cmd_start while busy SHALL be ignored.
REQ-019 The block SHALL assert at most one of avm_write and avm_read in any cycle, and SHALL drive both low in IDLE, POLL_WAIT, DONE and ERR.
REQ-020 A transfer SHALL complete in a cycle where its strobe is high and avm_waitrequest is low; while avm_waitrequest is high, address, strobe and writedata SHALL hold unchanged.
REQ-021 WR_DATA: write sample word k to address 1 for k = 0..3, one completed write per word, in order.
REQ-022 The slave keeps only the last data write, so all four writes target address 1; word 3 is the operand in effect.
REQ-023 After word 3 completes, the block SHALL enter WR_START and write 32'h1 to address 0, then enter POLL_RD.
REQ-024 POLL_RD: read address 0; on completion, increment the poll count.
REQ-025 On poll completion with avm_readdata[0]=1, the block SHALL enter RD_RES.
REQ-026 On poll completion with bit 0 = 0 and the poll count equal to TIMEOUT, the block SHALL enter ERR.
REQ-027 Otherwise on poll completion, the block SHALL enter POLL_WAIT for exactly POLL_GAP cycles, then return to POLL_RD.
REQ-028 RD_RES: read addresses 1,2,3,4 in order, storing each completed readdata into result word k of an internal buffer.
REQ-029 result_out SHALL update only as a whole 128-bit value, on entry to DONE.
REQ-030 DONE SHALL last one cycle with result_valid=1, then return to IDLE; busy falls in the IDLE cycle.
REQ-031 ERR SHALL last one cycle with timeout_err=1, leave result_out unchanged, then return to IDLE.
REQ-032 Minimum job latency with waitrequest always low and done on the first poll SHALL be 11 cycles from cmd_start to result_valid: 4 writes, 1 start write, 1 poll, 4 reads, 1 DONE cycle.
REQ-033 The poll counter SHALL be wide enough for TIMEOUT without wrap.
REQ-034 The POLL_GAP counter SHALL handle POLL_GAP=0 by going directly from POLL_RD to POLL_RD.

Reset
REQ-035 On reset_n low, immediately and regardless of state, the block SHALL return to IDLE.
REQ-036 Reset SHALL drive busy, avm_write, avm_read, result_valid and timeout_err to 0.
REQ-037 Reset SHALL clear avm_address, avm_writedata, result_out and all counters to 0.
REQ-038 Reset mid-transfer SHALL abandon the transfer; no resumption after reset_n rises.

Verification
REQ-039 sample_in=128'h4_3_2_1 (words 1..4), waitrequest=0, slave done on first poll, results 10,20,30,40 -> writes of 1,2,3,4 @addr1 then 1 @addr0, one read @0, reads @1..4; result_valid 11 cycles after cmd_start; result_out={40,30,20,10}.
REQ-040 Slave returns done=0 for 3 polls then 1, POLL_GAP=4 -> 4 polls spaced by 4 idle bus cycles, then results read; result_valid once.
REQ-041 waitrequest high 3 cycles on the 2nd data write and the 1st result read -> strobe, address and data held stable during stall; final results identical to REQ-039.
REQ-042 TIMEOUT=8, done never set -> exactly 8 status reads, timeout_err pulse, no result_valid, result_out unchanged, back to IDLE.
REQ-043 cmd_start pulsed during POLL_WAIT -> ignored, single job.
REQ-044 Reset asserted in RD_RES -> all outputs 0 asynchronously; next cmd_start runs a complete job.

Source files
------------

// File: rtl/fft_mm_master.sv
// Avalon-MM master that loads four sample words into an FFT slave, starts it,
// polls its status register and reads back four result words.
module fft_mm_master #(
    parameter int unsigned POLL_GAP = 4,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         cmd_start,
    input  logic [127:0] sample_in,
    output logic         busy,
    output logic [127:0] result_out,
    output logic         result_valid,
    output logic         timeout_err,
    output logic [31:0]  avm_address,
    output logic         avm_write,
    output logic         avm_read,
    output logic [31:0]  avm_writedata,
    input  logic [31:0]  avm_readdata,
    input  logic         avm_waitrequest
);

    localparam int unsigned PW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned GW = (POLL_GAP < 2) ? 1 : $clog2(POLL_GAP);
    localparam logic [PW-1:0] POLL_LIMIT = PW'(TIMEOUT);
    localparam logic [GW-1:0] GAP_LAST   = GW'((POLL_GAP == 0) ? 0 : POLL_GAP - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_START,
        POLL_RD,
        POLL_WAIT,
        RD_RES,
        DONE,
        ERR
    } state_t;

    state_t        state_q, state_d;
    logic [127:0]  sample_q, sample_d;
    logic [1:0]    idx_q, idx_d;
    logic [PW-1:0] poll_cnt_q, poll_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [127:0]  res_buf_q, res_buf_d;
    logic [127:0]  result_q, result_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            sample_q   <= '0;
            idx_q      <= '0;
            poll_cnt_q <= '0;
            gap_cnt_q  <= '0;
            res_buf_q  <= '0;
            result_q   <= '0;
        end else begin
            state_q    <= state_d;
            sample_q   <= sample_d;
            idx_q      <= idx_d;
            poll_cnt_q <= poll_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            res_buf_q  <= res_buf_d;
            result_q   <= result_d;
        end
    end

    // Bus outputs depend only on registered state, so they hold while stalled.
    always_comb begin
        state_d       = state_q;
        sample_d      = sample_q;
        idx_d         = idx_q;
        poll_cnt_d    = poll_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        res_buf_d     = res_buf_q;
        result_d      = result_q;
        avm_address   = '0;
        avm_write     = 1'b0;
        avm_read      = 1'b0;
        avm_writedata = '0;

        unique case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    sample_d   = sample_in;
                    idx_d      = '0;
                    poll_cnt_d = '0;
                    state_d    = WR_DATA;
                end
            end
            WR_DATA: begin
                avm_write     = 1'b1;
                avm_address   = 32'd1;
                avm_writedata = sample_q[{idx_q, 5'd0} +: 32];
                if (!avm_waitrequest) begin
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d = WR_START;
                    end
                end
            end
            WR_START: begin
                avm_write     = 1'b1;
                avm_address   = 32'd0;
                avm_writedata = 32'h1;
                if (!avm_waitrequest) begin
                    state_d = POLL_RD;
                end
            end
            POLL_RD: begin
                avm_read    = 1'b1;
                avm_address = 32'd0;
                if (!avm_waitrequest) begin
                    poll_cnt_d = poll_cnt_q + PW'(1);
                    if (avm_readdata[0]) begin
                        idx_d   = '0;
                        state_d = RD_RES;
                    end else if (poll_cnt_d == POLL_LIMIT) begin
                        state_d = ERR;
                    end else if (POLL_GAP != 0) begin
                        gap_cnt_d = '0;
                        state_d   = POLL_WAIT;
                    end
                end
            end
            POLL_WAIT: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = POLL_RD;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            RD_RES: begin
                avm_read    = 1'b1;
                avm_address = {30'd0, idx_q} + 32'd1;
                if (!avm_waitrequest) begin
                    res_buf_d[{idx_q, 5'd0} +: 32] = avm_readdata;
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        // Last word bypasses the buffer so result_out updates as one value.
                        result_d = {avm_readdata, res_buf_q[95:0]};
                        state_d  = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy         = (state_q != IDLE);
    assign result_valid = (state_q == DONE);
    assign timeout_err  = (state_q == ERR);
    assign result_out   = result_q;

endmodule

// File: tb/tb_fft_mm_master.sv
// Directed bench for fft_mm_master: a behavioural FFT slave with programmable
// stalls and done-delay, plus a vector table of jobs and hand-built corner cases.
module tb_fft_mm_master;

    localparam int unsigned GAP = 4;
    localparam int unsigned TO  = 8;

    logic         clk;
    logic         reset_n;
    logic         cmd_start;
    logic [127:0] sample_in;
    logic         busy;
    logic [127:0] result_out;
    logic         result_valid;
    logic         timeout_err;
    logic [31:0]  avm_address;
    logic         avm_write;
    logic         avm_read;
    logic [31:0]  avm_writedata;
    logic [31:0]  avm_readdata;
    logic         avm_waitrequest;

    fft_mm_master #(.POLL_GAP(GAP), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .cmd_start      (cmd_start),
        .sample_in      (sample_in),
        .busy           (busy),
        .result_out     (result_out),
        .result_valid   (result_valid),
        .timeout_err    (timeout_err),
        .avm_address    (avm_address),
        .avm_write      (avm_write),
        .avm_read       (avm_read),
        .avm_writedata  (avm_writedata),
        .avm_readdata   (avm_readdata),
        .avm_waitrequest(avm_waitrequest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } txn_t;

    typedef struct {
        logic [127:0] samples;
        logic [127:0] res;
        int           done_after;
        int           stall1;
        int           stall2;
        int           exp_stalls;
        int           exp_lat;
        logic [127:0] exp_result;
    } vec_t;

    // Slave configuration (written by the test sequence)
    int           s_stall_a    = -1;
    int           s_stall_b    = -1;
    int           s_done_after = 0;
    int           s_poll_base  = 0;
    logic [127:0] s_res        = '0;

    // Slave state (advanced on the clock edge)
    int txn_n     = 0;
    int stall_cnt = 0;
    int poll_n    = 0;
    int cyc       = 0;

    // Monitor state (sampled on the falling edge)
    txn_t        log_q[$];
    int          rv_cnt     = 0;
    int          te_cnt     = 0;
    int          rv_cyc     = 0;
    int          te_cyc     = 0;
    int          stall_seen = 0;
    int          stall_bad  = 0;
    int          both_bad   = 0;
    logic        p_stall    = 1'b0;
    logic        p_w        = 1'b0;
    logic        p_r        = 1'b0;
    logic [31:0] p_a        = '0;
    logic [31:0] p_d        = '0;

    assign avm_waitrequest = (avm_write || avm_read) &&
                             (txn_n == s_stall_a || txn_n == s_stall_b) && (stall_cnt < 3);

    always_comb begin
        avm_readdata = 32'hDEAD_0000;
        case (avm_address)
            32'd0:   avm_readdata = ((poll_n - s_poll_base) >= s_done_after) ? 32'd1 : 32'd0;
            32'd1:   avm_readdata = s_res[31:0];
            32'd2:   avm_readdata = s_res[63:32];
            32'd3:   avm_readdata = s_res[95:64];
            32'd4:   avm_readdata = s_res[127:96];
            default: ;
        endcase
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (avm_write || avm_read) begin
            if (avm_waitrequest) begin
                stall_cnt <= stall_cnt + 1;
            end else begin
                txn_n     <= txn_n + 1;
                stall_cnt <= 0;
                if (avm_read && avm_address == 32'd0) poll_n <= poll_n + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (avm_write && avm_read) both_bad <= both_bad + 1;
        if (p_stall && (avm_write !== p_w || avm_read !== p_r ||
                        avm_address !== p_a || avm_writedata !== p_d))
            stall_bad <= stall_bad + 1;
        p_stall <= (avm_write || avm_read) && avm_waitrequest;
        if ((avm_write || avm_read) && avm_waitrequest) stall_seen <= stall_seen + 1;
        p_w <= avm_write;
        p_r <= avm_read;
        p_a <= avm_address;
        p_d <= avm_writedata;
        if ((avm_write || avm_read) && !avm_waitrequest)
            log_q.push_back('{we: avm_write, addr: avm_address,
                              data: avm_write ? avm_writedata : avm_readdata, cyc: cyc});
        if (result_valid) begin
            rv_cnt <= rv_cnt + 1;
            rv_cyc <= cyc;
        end
        if (timeout_err) begin
            te_cnt <= te_cnt + 1;
            te_cyc <= cyc;
        end
    end

    int n_chk  = 0;
    int n_pass = 0;

    int job_log_base, job_rv0, job_te0, job_start_cyc, job_stall0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_txn(input string name, input int k, input logic we,
                           input logic [31:0] addr, input logic [31:0] data);
        logic [64:0] act;
        if (k < log_q.size()) act = {log_q[k].we, log_q[k].addr, log_q[k].data};
        else act = '1;
        chk(name, {63'd0, act}, {63'd0, we, addr, data});
    endtask

    task automatic start_job(input vec_t v);
        s_res        = v.res;
        s_done_after = v.done_after;
        s_poll_base  = poll_n;
        s_stall_a    = (v.stall1 >= 0) ? txn_n + v.stall1 : -1;
        s_stall_b    = (v.stall2 >= 0) ? txn_n + v.stall2 : -1;
        job_log_base = log_q.size();
        job_rv0      = rv_cnt;
        job_te0      = te_cnt;
        job_stall0   = stall_seen;
        sample_in    = v.samples;
        cmd_start    = 1'b1;
        job_start_cyc = cyc;
        tick(1);
        cmd_start    = 1'b0;
    endtask

    task automatic wait_job();
        for (int i = 0; i < 400 && rv_cnt == job_rv0 && te_cnt == job_te0; i++) tick(1);
        if (rv_cnt == job_rv0 && te_cnt == job_te0)
            chk("job_end_wait", {96'd0, rv_cnt, te_cnt}, {96'd0, job_rv0 + 1, job_te0});
        tick(2);
    endtask

    task automatic check_log(input vec_t v, input int np, input bit with_reads);
        int k;
        k = job_log_base;
        for (int j = 0; j < 4; j++) begin
            chk_txn("wr_data", k, 1'b1, 32'd1, v.samples[32*j +: 32]);
            k++;
        end
        chk_txn("wr_start", k, 1'b1, 32'd0, 32'd1);
        k++;
        for (int p = 0; p < np; p++) begin
            chk_txn("poll_rd", k, 1'b0, 32'd0, (with_reads && p == np - 1) ? 32'd1 : 32'd0);
            if (p > 0 && k < log_q.size())
                chk("poll_spacing", log_q[k].cyc - log_q[k-1].cyc, GAP + 1);
            k++;
        end
        if (with_reads) begin
            for (int j = 0; j < 4; j++) begin
                chk_txn("rd_res", k, 1'b0, 32'(j + 1), v.res[32*j +: 32]);
                k++;
            end
        end
    endtask

    task automatic check_job(input vec_t v);
        chk("rv_pulses", rv_cnt - job_rv0, 1);
        chk("no_timeout_err", te_cnt - job_te0, 0);
        chk("latency", rv_cyc - job_start_cyc, v.exp_lat);
        chk("result_out", result_out, v.exp_result);
        chk("txn_count", log_q.size() - job_log_base, 10 + v.done_after);
        check_log(v, v.done_after + 1, 1'b1);
        chk("stall_stable", stall_bad, 0);
        chk("stall_cycles", stall_seen - job_stall0, v.exp_stalls);
        chk("one_strobe", both_bad, 0);
        chk("idle_busy", {126'd0, busy, avm_write | avm_read}, 0);
    endtask

    vec_t vecs[4];
    vec_t vt, vc;
    logic [127:0] prev_result;
    int base2, rv_before;

    initial begin
        vecs[0] = '{samples: 128'h00000004_00000003_00000002_00000001,
                    res: 128'h00000028_0000001E_00000014_0000000A,
                    done_after: 0, stall1: -1, stall2: -1, exp_stalls: 0, exp_lat: 11,
                    exp_result: 128'h00000028_0000001E_00000014_0000000A};
        vecs[1] = '{samples: 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0,
                    res: 128'h44444444_33333333_22222222_11111111,
                    done_after: 3, stall1: -1, stall2: -1, exp_stalls: 0, exp_lat: 26,
                    exp_result: 128'h44444444_33333333_22222222_11111111};
        vecs[2] = '{samples: 128'h00000004_00000003_00000002_00000001,
                    res: 128'h00000028_0000001E_00000014_0000000A,
                    done_after: 0, stall1: 1, stall2: 6, exp_stalls: 6, exp_lat: 17,
                    exp_result: 128'h00000028_0000001E_00000014_0000000A};
        vecs[3] = '{samples: 128'hFFFFFFFF_00000000_A5A5A5A5_5A5A5A5A,
                    res: 128'h80000000_00000001_7FFFFFFF_FFFFFFFF,
                    done_after: 1, stall1: 5, stall2: -1, exp_stalls: 3, exp_lat: 19,
                    exp_result: 128'h80000000_00000001_7FFFFFFF_FFFFFFFF};

        reset_n   = 1'b0;
        cmd_start = 1'b0;
        sample_in = '0;
        tick(3);
        chk("reset_ctrl", {123'd0, busy, avm_write, avm_read, result_valid, timeout_err}, 0);
        chk("reset_addr_data", {64'd0, avm_address, avm_writedata}, 0);
        chk("reset_result", result_out, 0);
        reset_n = 1'b1;
        tick(2);

        for (int i = 0; i < 4; i++) begin
            start_job(vecs[i]);
            wait_job();
            check_job(vecs[i]);
            tick(3);
        end

        // Timeout: status never reports done
        prev_result = result_out;
        vt = '{samples: 128'h11111111_22222222_33333333_44444444, res: '0,
               done_after: 1000, stall1: -1, stall2: -1, exp_stalls: 0, exp_lat: 0,
               exp_result: '0};
        start_job(vt);
        wait_job();
        chk("to_err_pulses", te_cnt - job_te0, 1);
        chk("to_no_rv", rv_cnt - job_rv0, 0);
        chk("to_latency", te_cyc - job_start_cyc, 42);
        chk("to_txn_count", log_q.size() - job_log_base, 13);
        check_log(vt, 8, 1'b0);
        chk("to_result_kept", result_out, 128'h80000000_00000001_7FFFFFFF_FFFFFFFF);
        chk("to_result_same", result_out, prev_result);
        chk("to_idle", {127'd0, busy}, 0);
        tick(3);

        // cmd_start during POLL_WAIT is ignored
        vc = '{samples: 128'h00000004_00000003_00000002_00000001,
               res: 128'h00000028_0000001E_00000014_0000000A,
               done_after: 2, stall1: -1, stall2: -1, exp_stalls: 0, exp_lat: 21,
               exp_result: 128'h00000028_0000001E_00000014_0000000A};
        start_job(vc);
        for (int i = 0; i < 50 && (poll_n - s_poll_base) < 1; i++) tick(1);
        chk("pw_state", {125'd0, busy, avm_write, avm_read}, {125'd0, 3'b100});
        sample_in = 128'h77777777_77777777_77777777_77777777;
        cmd_start = 1'b1;
        tick(1);
        cmd_start = 1'b0;
        wait_job();
        check_job(vc);
        tick(20);
        chk("single_job_txns", log_q.size() - job_log_base, 12);
        chk("single_job_rv", rv_cnt - job_rv0, 1);

        // Asynchronous reset in RD_RES abandons the job
        start_job(vecs[0]);
        for (int i = 0; i < 50 && log_q.size() < job_log_base + 7; i++) tick(1);
        chk("pre_reset_rd_res", {95'd0, avm_read, avm_address}, {95'd0, 1'b1, 32'd2});
        rv_before = rv_cnt;
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_ctrl", {123'd0, busy, avm_write, avm_read, result_valid, timeout_err}, 0);
        chk("arst_addr_data", {64'd0, avm_address, avm_writedata}, 0);
        chk("arst_result", result_out, 0);
        tick(1);
        reset_n = 1'b1;
        base2 = log_q.size();
        tick(10);
        chk("no_resume_txns", log_q.size() - base2, 0);
        chk("no_resume_rv", rv_cnt - rv_before, 0);
        chk("no_resume_busy", {127'd0, busy}, 0);
        start_job(vecs[0]);
        wait_job();
        check_job(vecs[0]);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
